crossbar_onein_router: RTL and testbench

One-input, N-output routing stage: the fan-out counterpart of the N-to-one input-select crossbar. It accepts a message on a single val/rdy input, holds it in a one-entry output buffer, and presents it on the output selected by a stored control word. It sits on the egress side of the interconnect, feeding N downstream val/rdy consumers from one upstream producer.

---
 rtl/crossbar_onein_router.sv | 147 ++++++++++++++
 tb/tb_crossbar_onein_router.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_onein_router.sv
// crossbar_onein_router
//   One-input, N-output val/rdy routing stage with a one-entry output buffer.
//   A stored control word selects the destination output for each accepted
//   message. The top $clog2(N_OUTPUTS) bits of the control word form the
//   output select.
//
//   Optional feature macro: CROSSBAR_ONEIN_BROADCAST_EN
//     When defined, control bit [CONTROL_BIT_WIDTH-1-$clog2(N_OUTPUTS)] is a
//     broadcast flag. A broadcast message is presented on every output and
//     each output takes it once. The buffer frees when the last output has
//     taken it. When the macro is undefined, the block is unicast only.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        asynchronous, active-low reset
//   recv_msg     input message            recv_val / recv_rdy   input handshake
//   send_msg     per-output message       send_val / send_rdy   per-output handshake
//   control      routing control word     control_val / control_rdy
module crossbar_onein_router #(
  parameter int unsigned BIT_WIDTH         = 32,
  parameter int unsigned N_OUTPUTS         = 2,
  parameter int unsigned CONTROL_BIT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BIT_WIDTH-1:0]         recv_msg,
  input  logic                         recv_val,
  output logic                         recv_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg [0:N_OUTPUTS-1],
  output logic [0:N_OUTPUTS-1]         send_val,
  input  logic [0:N_OUTPUTS-1]         send_rdy,
  input  logic [CONTROL_BIT_WIDTH-1:0] control,
  input  logic                         control_val,
  output logic                         control_rdy
);

  localparam int unsigned    SEL_W = $clog2(N_OUTPUTS);
  localparam logic [SEL_W:0] N_OUT = (SEL_W+1)'(N_OUTPUTS);

  logic [CONTROL_BIT_WIDTH-1:0] stored_control;
  logic [BIT_WIDTH-1:0]         buf_msg;
  logic                         buf_full;
  logic                         active;
  logic                         drain;
  logic                         accept;
  logic                         ctrl_accept;
  logic                         load;
  logic                         sel_in_range;
  logic [SEL_W-1:0]             output_sel;
  logic                         unused_ctrl;

  assign output_sel   = stored_control[CONTROL_BIT_WIDTH-1 -: SEL_W];
  assign sel_in_range = {1'b0, output_sel} < N_OUT;

  // Both ready outputs stay low through reset and come up on the first
  // clock edge after release. The active flop provides that behaviour.
  assign control_rdy  = active & ~buf_full;
  assign recv_rdy     = active & (~buf_full | drain);
  assign accept       = recv_val & recv_rdy;
  assign ctrl_accept  = control_val & control_rdy;

  // Only the select (and broadcast flag) bits are consumed.
  assign unused_ctrl  = ^stored_control;

`ifdef CROSSBAR_ONEIN_BROADCAST_EN
  logic [0:N_OUTPUTS-1] pending;
  logic [0:N_OUTPUTS-1] pending_left;
  logic [0:N_OUTPUTS-1] dest_mask;
  logic                 bcast;

  assign bcast = stored_control[CONTROL_BIT_WIDTH-1-SEL_W];

  always_comb begin
    dest_mask = '0;
    for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
      if (output_sel == SEL_W'(i)) dest_mask[i] = 1'b1;
    end
  end

  // A unicast message is handled as a broadcast with a one-hot pending mask.
  // The buffer then drains when the last pending output completes its
  // handshake.
  assign send_val     = buf_full ? pending : '0;
  assign pending_left = pending & ~(send_val & send_rdy);
  assign drain        = buf_full & (pending_left == '0);
  assign load         = accept & (bcast | sel_in_range);

  always_comb begin
    for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
      send_msg[i] = send_val[i] ? buf_msg : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else if (load) begin
      pending <= bcast ? '1 : dest_mask;
    end else if (drain) begin
      pending <= '0;
    end else begin
      pending <= pending_left;
    end
  end
`else
  logic [SEL_W-1:0] buf_dest;

  assign load  = accept & sel_in_range;
  assign drain = |(send_val & send_rdy);

  always_comb begin
    for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
      send_val[i] = buf_full & (buf_dest == SEL_W'(i));
      send_msg[i] = (buf_dest == SEL_W'(i)) ? buf_msg : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_dest <= '0;
    end else if (load) begin
      buf_dest <= output_sel;
    end
  end
`endif

  // A message with an out-of-range select is accepted and then dropped.
  // It never sets buf_full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active         <= 1'b0;
      stored_control <= '0;
      buf_msg        <= '0;
      buf_full       <= 1'b0;
    end else begin
      active <= 1'b1;
      if (ctrl_accept) stored_control <= control;
      if (load) begin
        buf_msg  <= recv_msg;
        buf_full <= 1'b1;
      end else if (drain) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crossbar_onein_router.sv
module tb_crossbar_onein_router;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-output instance
  logic [31:0] a_recv_msg, a_control;
  logic        a_recv_val, a_recv_rdy, a_control_val, a_control_rdy;
  logic [31:0] a_send_msg [0:1];
  logic [0:1]  a_send_val, a_send_rdy;

  crossbar_onein_router #(.BIT_WIDTH(32), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .recv_msg(a_recv_msg), .recv_val(a_recv_val), .recv_rdy(a_recv_rdy),
    .send_msg(a_send_msg), .send_val(a_send_val), .send_rdy(a_send_rdy),
    .control(a_control), .control_val(a_control_val), .control_rdy(a_control_rdy)
  );

  // Three-output instance, exercises the out-of-range select
  logic [31:0] c_recv_msg, c_control;
  logic        c_recv_val, c_recv_rdy, c_control_val, c_control_rdy;
  logic [31:0] c_send_msg [0:2];
  logic [0:2]  c_send_val, c_send_rdy;

  crossbar_onein_router #(.BIT_WIDTH(32), .N_OUTPUTS(3), .CONTROL_BIT_WIDTH(32)) dut3 (
    .clk(clk), .reset(reset),
    .recv_msg(c_recv_msg), .recv_val(c_recv_val), .recv_rdy(c_recv_rdy),
    .send_msg(c_send_msg), .send_val(c_send_val), .send_rdy(c_send_rdy),
    .control(c_control), .control_val(c_control_val), .control_rdy(c_control_rdy)
  );

`ifdef CROSSBAR_ONEIN_BROADCAST_EN
  logic [31:0] b_recv_msg, b_control;
  logic        b_recv_val, b_recv_rdy, b_control_val, b_control_rdy;
  logic [31:0] b_send_msg [0:3];
  logic [0:3]  b_send_val, b_send_rdy;

  crossbar_onein_router #(.BIT_WIDTH(32), .N_OUTPUTS(4), .CONTROL_BIT_WIDTH(32)) dut4 (
    .clk(clk), .reset(reset),
    .recv_msg(b_recv_msg), .recv_val(b_recv_val), .recv_rdy(b_recv_rdy),
    .send_msg(b_send_msg), .send_val(b_send_val), .send_rdy(b_send_rdy),
    .control(b_control), .control_val(b_control_val), .control_rdy(b_control_rdy)
  );
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    a_recv_msg = '0; a_recv_val = 1'b0; a_send_rdy = '0; a_control = '0; a_control_val = 1'b0;
    c_recv_msg = '0; c_recv_val = 1'b0; c_send_rdy = '0; c_control = '0; c_control_val = 1'b0;
`ifdef CROSSBAR_ONEIN_BROADCAST_EN
    b_recv_msg = '0; b_recv_val = 1'b0; b_send_rdy = '0; b_control = '0; b_control_val = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst send_val", 64'(a_send_val), 64'h0);
    check("rst send_msg0", 64'(a_send_msg[0]), 64'h0);
    check("rst recv_rdy", 64'(a_recv_rdy), 64'h0);
    check("rst control_rdy", 64'(a_control_rdy), 64'h0);
    reset = 1'b1;
    #1;
    check("rdy before first edge", 64'(a_recv_rdy), 64'h0);
    tick();
    check("recv_rdy after release", 64'(a_recv_rdy), 64'h1);
    check("control_rdy after release", 64'(a_control_rdy), 64'h1);

    // Default control routes to output 0, then back-pressure
    a_recv_msg = 32'h11; a_recv_val = 1'b1; a_send_rdy = 2'b00;
    tick();
    a_recv_val = 1'b0;
    check("def val0", 64'(a_send_val[0]), 64'h1);
    check("def val1", 64'(a_send_val[1]), 64'h0);
    check("def msg0", 64'(a_send_msg[0]), 64'h11);
    check("def msg1", 64'(a_send_msg[1]), 64'h0);
    for (int k = 0; k < 3; k++) begin
      a_control = 32'h8000_0000; a_control_val = 1'b1;
      #1;
      check("bp recv_rdy", 64'(a_recv_rdy), 64'h0);
      check("bp control_rdy", 64'(a_control_rdy), 64'h0);
      check("bp msg0", 64'(a_send_msg[0]), 64'h11);
      check("bp val0", 64'(a_send_val[0]), 64'h1);
      tick();
    end
    a_send_rdy = 2'b10;
    #1;
    check("drain recv_rdy", 64'(a_recv_rdy), 64'h1);
    check("drain control_rdy", 64'(a_control_rdy), 64'h0);
    tick();
    check("drained val0", 64'(a_send_val[0]), 64'h0);
    check("ctrl rdy after drain", 64'(a_control_rdy), 64'h1);
    tick();
    a_control_val = 1'b0;

    // Select 1 from control 0x80000000
    a_send_rdy = 2'b11; a_recv_msg = 32'hA5; a_recv_val = 1'b1;
    tick();
    a_recv_val = 1'b0;
    check("sel1 val1", 64'(a_send_val[1]), 64'h1);
    check("sel1 msg1", 64'(a_send_msg[1]), 64'hA5);
    check("sel1 val0", 64'(a_send_val[0]), 64'h0);
    check("sel1 msg0", 64'(a_send_msg[0]), 64'h0);
    tick();
    check("sel1 drained", 64'(a_send_val[1]), 64'h0);

    // Control written with a message in the same cycle: the old select applies
    a_control = 32'h0; a_control_val = 1'b1; a_recv_msg = 32'h77; a_recv_val = 1'b1;
    tick();
    a_control_val = 1'b0; a_recv_val = 1'b0;
    check("samecyc val1", 64'(a_send_val[1]), 64'h1);
    check("samecyc msg1", 64'(a_send_msg[1]), 64'h77);
    check("samecyc val0", 64'(a_send_val[0]), 64'h0);
    tick();

    // Stream 1,2,3 to output 0 at one message per cycle
    for (int i = 1; i <= 3; i++) begin
      a_recv_msg = 32'(i); a_recv_val = 1'b1;
      #1;
      check("stream recv_rdy", 64'(a_recv_rdy), 64'h1);
      tick();
      check("stream val0", 64'(a_send_val[0]), 64'h1);
      check("stream msg0", 64'(a_send_msg[0]), 64'(i));
    end
    a_recv_val = 1'b0;
    tick();
    check("stream end val0", 64'(a_send_val[0]), 64'h0);

    // Reset with the buffer full
    a_control = 32'h8000_0000; a_control_val = 1'b1;
    tick();
    a_control_val = 1'b0; a_send_rdy = 2'b00; a_recv_msg = 32'hCC; a_recv_val = 1'b1;
    tick();
    a_recv_val = 1'b0;
    check("pre-rst val1", 64'(a_send_val[1]), 64'h1);
    check("pre-rst msg1", 64'(a_send_msg[1]), 64'hCC);
    #2 reset = 1'b0;
    #1;
    check("midrst send_val", 64'(a_send_val), 64'h0);
    check("midrst msg1", 64'(a_send_msg[1]), 64'h0);
    check("midrst recv_rdy", 64'(a_recv_rdy), 64'h0);
    #1 reset = 1'b1;
    tick();
    check("post-rst recv_rdy", 64'(a_recv_rdy), 64'h1);
    a_recv_msg = 32'h3C; a_recv_val = 1'b1;
    tick();
    a_recv_val = 1'b0;
    check("post-rst val0", 64'(a_send_val[0]), 64'h1);
    check("post-rst msg0", 64'(a_send_msg[0]), 64'h3C);
    check("post-rst val1", 64'(a_send_val[1]), 64'h0);
    a_send_rdy = 2'b11;
    tick();

    // Three outputs: select 3 is out of range, select 2 is the last valid
    c_control = 32'hC000_0000; c_control_val = 1'b1;
    tick();
    c_control_val = 1'b0; c_recv_msg = 32'hDE; c_recv_val = 1'b1;
    #1;
    check("oor recv_rdy pre", 64'(c_recv_rdy), 64'h1);
    tick();
    c_recv_val = 1'b0;
    check("oor send_val", 64'(c_send_val), 64'h0);
    check("oor recv_rdy", 64'(c_recv_rdy), 64'h1);
    check("oor control_rdy", 64'(c_control_rdy), 64'h1);
    c_control = 32'h8000_0000; c_control_val = 1'b1;
    tick();
    c_control_val = 1'b0; c_recv_msg = 32'hBE; c_recv_val = 1'b1;
    tick();
    c_recv_val = 1'b0;
    check("sel2 val2", 64'(c_send_val[2]), 64'h1);
    check("sel2 msg2", 64'(c_send_msg[2]), 64'hBE);
    check("sel2 val0", 64'(c_send_val[0]), 64'h0);

`ifdef CROSSBAR_ONEIN_BROADCAST_EN
    begin
      int unsigned hits [0:3];
      logic [0:3]  pats [0:5];
      logic        exp_rdy [0:5];
      pats[0] = 4'b0010; exp_rdy[0] = 1'b0;
      pats[1] = 4'b1001; exp_rdy[1] = 1'b0;
      pats[2] = 4'b0000; exp_rdy[2] = 1'b0;
      pats[3] = 4'b0100; exp_rdy[3] = 1'b1;
      pats[4] = 4'b1111; exp_rdy[4] = 1'b1;
      pats[5] = 4'b1111; exp_rdy[5] = 1'b1;
      for (int i = 0; i < 4; i++) hits[i] = 0;
      b_control = 32'h2000_0000; b_control_val = 1'b1;
      tick();
      b_control_val = 1'b0; b_recv_msg = 32'h55; b_recv_val = 1'b1;
      tick();
      b_recv_val = 1'b0;
      check("bc send_val", 64'(b_send_val), 64'hF);
      for (int s = 0; s < 6; s++) begin
        b_send_rdy = pats[s];
        #1;
        for (int i = 0; i < 4; i++) begin
          if (b_send_val[i] && b_send_rdy[i] && b_send_msg[i] == 32'h55) hits[i]++;
        end
        check("bc recv_rdy", 64'(b_recv_rdy), 64'(exp_rdy[s]));
        tick();
      end
      for (int i = 0; i < 4; i++) check("bc hits", 64'(hits[i]), 64'h1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
